// File: rtl/mac_seq_ctrl_if.sv
// Bundle of job control, operand stream, MAC connection and result handshake
// for the int8 MAC sequencer.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;

    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic             mac_clear;
    logic [ACC_W-1:0] mac_acc;

    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;

    // The environment side: operand fetch, MAC instance and result consumer.
    modport master (
        output start, len, abort, in_valid, in_a, in_b, mac_acc, res_ready,
        input  busy, in_ready, mac_a, mac_b, mac_clear, res_valid, res_data
    );

    modport slave (
        input  start, len, abort, in_valid, in_a, in_b, mac_acc, res_ready,
        output busy, in_ready, mac_a, mac_b, mac_clear, res_valid, res_data
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one int8 MAC: clear, stream N operand pairs, wait out the
// MAC register stage, then hold the dot-product result until it is taken.
module mac_seq_ctrl #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] res_q;

    logic             fire;
    logic             busy_c;
    logic             in_ready_c;
    logic             mac_clear_c;
    logic             res_valid_c;
    logic [7:0]       mac_a_c;
    logic [7:0]       mac_b_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Abort outranks every other transition outside IDLE; operands reach the
    // MAC only on a fire so gap cycles leave the accumulator untouched.
    always_comb begin
        state_nx    = state;
        busy_c      = 1'b1;
        in_ready_c  = 1'b0;
        mac_clear_c = 1'b0;
        res_valid_c = 1'b0;
        fire        = 1'b0;
        mac_a_c     = 8'd0;
        mac_b_c     = 8'd0;
        case (state)
            IDLE: begin
                busy_c      = 1'b0;
                mac_clear_c = 1'b1;
                if (bus.start) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                mac_clear_c = 1'b1;
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (len_q != '0) begin
                    state_nx = RUN;
                end else begin
                    state_nx = DRAIN;
                end
            end
            RUN: begin
                in_ready_c = 1'b1;
                fire       = bus.in_valid;
                if (fire) begin
                    mac_a_c = bus.in_a;
                    mac_b_c = bus.in_b;
                end
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (fire && (cnt == len_q - LEN_W'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = bus.abort ? IDLE : DONE;
            end
            DONE: begin
                res_valid_c = 1'b1;
                if (bus.abort || bus.res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The MAC output settles one edge after the last fire, so DRAIN is the
    // cycle in which the accumulator holds the complete sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                len_q <= bus.len;
            end
            if (state == CLEAR) begin
                cnt <= '0;
            end else if (fire) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (state == DRAIN && !bus.abort) begin
                res_q <= bus.mac_acc;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.mac_clear = mac_clear_c;
    assign bus.mac_a     = mac_a_c;
    assign bus.mac_b     = mac_b_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_q;
endmodule
